// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for a common-anode 7-segment display with
//   NUM_DIGITS digits. Features:
//     * digit scan at SCAN_FREQUENCY (one digit slot per tick)
//     * tear-free double-buffered loads (staging -> shadow at frame boundary)
//     * 16-level PWM brightness within each digit slot
//     * optional leading-zero suppression
//     * optional per-digit blinking, compiled in only when the macro
//       SEG7_BLINK_EN is defined (the blink port always exists)
//   All pin outputs are active-low and registered.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int NUM_DIGITS      = 4,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int SCAN_FREQUENCY  = 1000,
  parameter int BLINK_FRAMES    = 125
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] input_hex,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [3:0]              brightness,
  input  logic                    lzs,
  input  logic [NUM_DIGITS-1:0]   blink,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int TICK_DIV = CLOCK_FREQUENCY / SCAN_FREQUENCY;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(32'd1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(32'd1);

  // -------------------------------------------------------------------------
  // Hex digit to active-low segment pattern, bit order {g,f,e,d,c,b,a}
  // -------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      4'hF:    pattern = 7'h0E;
      default: pattern = 7'h7F;
    endcase
    return pattern;
  endfunction

  // -------------------------------------------------------------------------
  // Internal state
  // -------------------------------------------------------------------------
  logic [TICK_W-1:0]       tick_cnt_r;
  logic                    tick_s;
  logic [IDX_W-1:0]        index_r;
  logic                    frame_s;
  logic [3:0]              pwm_r;

  logic [4*NUM_DIGITS-1:0] staging_hex_r;
  logic [NUM_DIGITS-1:0]   staging_dp_r;
  logic                    pending_r;
  logic [4*NUM_DIGITS-1:0] shadow_hex_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r;

  logic [NUM_DIGITS-1:0]   blank_lz_s;
  logic [NUM_DIGITS-1:0]   blink_mask_s;
  logic [3:0]              cur_digit_s;
  logic                    cur_dp_s;
  logic                    cur_blank_s;
  logic                    lit_s;
  logic                    show_s;

  logic [NUM_DIGITS-1:0]   an_s;
  logic [6:0]              seg_s;
  logic                    dp_s;

  // -------------------------------------------------------------------------
  // Scan timing
  // -------------------------------------------------------------------------
  assign tick_s  = (tick_cnt_r == TICK_LAST);
  assign frame_s = tick_s && (index_r == IDX_LAST);

  // Tick prescaler: free-running 0..TICK_DIV-1 counter
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_ONE;
    end
  end

  // Digit index: advances one slot per tick, wrapping after the last digit
  always_ff @(posedge clk) begin
    if (rst) begin
      index_r <= {IDX_W{1'b0}};
    end else if (tick_s) begin
      if (index_r == IDX_LAST) begin
        index_r <= {IDX_W{1'b0}};
      end else begin
        index_r <= index_r + IDX_ONE;
      end
    end else begin
      index_r <= index_r;
    end
  end

  // PWM phase within a digit slot; realigned to 0 at the start of every slot
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_r <= 4'h0;
    end else if (tick_s) begin
      pwm_r <= 4'h0;
    end else begin
      pwm_r <= pwm_r + 4'h1;
    end
  end

  // -------------------------------------------------------------------------
  // Double-buffered display data. A load outside a frame boundary is parked
  // in staging (later loads overwrite it) and only promoted to the shadow at
  // the next boundary, so a frame never mixes old and new digits. A load
  // that coincides with the boundary goes straight to the shadow and
  // supersedes anything still pending.
  // -------------------------------------------------------------------------

  // Staging, pending flag and shadow update
  always_ff @(posedge clk) begin
    if (rst) begin
      staging_hex_r <= {(4*NUM_DIGITS){1'b0}};
      staging_dp_r  <= {NUM_DIGITS{1'b0}};
      pending_r     <= 1'b0;
      shadow_hex_r  <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r   <= {NUM_DIGITS{1'b0}};
    end else if (load && frame_s) begin
      shadow_hex_r  <= input_hex;
      shadow_dp_r   <= dp_in;
      pending_r     <= 1'b0;
    end else if (load) begin
      staging_hex_r <= input_hex;
      staging_dp_r  <= dp_in;
      pending_r     <= 1'b1;
    end else if (frame_s && pending_r) begin
      shadow_hex_r  <= staging_hex_r;
      shadow_dp_r   <= staging_dp_r;
      pending_r     <= 1'b0;
    end else begin
      pending_r     <= pending_r;
    end
  end

  // -------------------------------------------------------------------------
  // Blink phase (optional)
  // -------------------------------------------------------------------------
`ifdef SEG7_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(32'd1);

  logic [FC_W-1:0] frame_cnt_r;
  logic            blink_phase_r;

  // Frame counter: toggles the blink phase every BLINK_FRAMES frames
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r   <= {FC_W{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (frame_s) begin
      if (frame_cnt_r == FC_LAST) begin
        frame_cnt_r   <= {FC_W{1'b0}};
        blink_phase_r <= ~blink_phase_r;
      end else begin
        frame_cnt_r   <= frame_cnt_r + FC_ONE;
      end
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Digits flagged for blinking are blanked during the hidden phase
  always_comb begin
    if (blink_phase_r) begin
      blink_mask_s = blink;
    end else begin
      blink_mask_s = {NUM_DIGITS{1'b0}};
    end
  end
`else
  logic unused_blink_s;
  assign unused_blink_s = ^blink;

  // Blinking not built in: no digit is ever blink-blanked
  always_comb begin
    blink_mask_s = {NUM_DIGITS{1'b0}};
  end
`endif

  // -------------------------------------------------------------------------
  // Pixel decision for the current slot
  // -------------------------------------------------------------------------

  // Leading-zero blanking: walk from the most significant digit down and
  // blank zeros until the first non-zero digit; digit 0 always shows
  always_comb begin
    logic seen_nonzero;
    seen_nonzero = 1'b0;
    blank_lz_s   = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (shadow_hex_r[4*i +: 4] != 4'h0) begin
        seen_nonzero = 1'b1;
      end else begin
        seen_nonzero = seen_nonzero;
      end
      blank_lz_s[i] = lzs && !seen_nonzero && (i != 0);
    end
  end

  // Select the shadow digit, decimal point and blank flag for this slot
  always_comb begin
    cur_digit_s = shadow_hex_r[{index_r, 2'b00} +: 4];
    cur_dp_s    = shadow_dp_r[index_r];
    cur_blank_s = blank_lz_s[index_r] | blink_mask_s[index_r];
    lit_s       = (brightness == 4'hF) || (pwm_r < brightness);
    show_s      = lit_s && !cur_blank_s;
  end

  // Next pin values: one active-low anode plus its segments, or all dark
  always_comb begin
    an_s  = {NUM_DIGITS{1'b1}};
    seg_s = 7'h7F;
    dp_s  = 1'b1;
    if (show_s) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_s[i] = (index_r == IDX_W'(i)) ? 1'b0 : 1'b1;
      end
      seg_s = hex_to_seg(cur_digit_s);
      dp_s  = ~cur_dp_s;
    end else begin
      an_s  = {NUM_DIGITS{1'b1}};
      seg_s = 7'h7F;
      dp_s  = 1'b1;
    end
  end

  // Output pin register: glitch-free pins, all dark during reset
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= {NUM_DIGITS{1'b1}};
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_s;
      seg <= seg_s;
      dp  <= dp_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Scoreboard bench for seg7_scan_driver (4 digits, TICK_DIV = 16).
//   A reference model derives the expected pins from the cycle count since
//   reset and the load history; a monitor compares them every cycle.
//   Directed scenarios are followed by randomized stimulus.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int ND        = 4;
  localparam int CLK_HZ    = 1600;
  localparam int SCAN_HZ   = 100;
  localparam int BF        = 2;
  localparam int TICK_DIV  = CLK_HZ / SCAN_HZ;
  localparam int FRAME_LEN = TICK_DIV * ND;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } pins_t;

  localparam pins_t PINS_OFF = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

  logic        clk;
  logic        rst;
  logic [15:0] input_hex;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  brightness;
  logic        lzs;
  logic [3:0]  blink;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int    checks = 0;
  int    errors = 0;
  pins_t exp_q[$];

  seg7_scan_driver #(
    .NUM_DIGITS      (ND),
    .CLOCK_FREQUENCY (CLK_HZ),
    .SCAN_FREQUENCY  (SCAN_HZ),
    .BLINK_FRAMES    (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .input_hex  (input_hex),
    .dp_in      (dp_in),
    .load       (load),
    .brightness (brightness),
    .lzs        (lzs),
    .blink      (blink),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Standard active-low 7-segment table
  function automatic logic [6:0] exp_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model: expected pins after each rising edge
  initial begin : ref_model
    int          n;
    int          frames;
    int          slot;
    int          pwm;
    bit          frame_edge;
    bit          blank;
    bit          lit;
    logic [15:0] shadow_m;
    logic [15:0] stage_m;
    logic [3:0]  sdp_m;
    logic [3:0]  stage_dp_m;
    bit          pend_m;
    logic [3:0]  v;
    pins_t       e;
    n = 0; frames = 0; shadow_m = 16'h0; stage_m = 16'h0;
    sdp_m = 4'h0; stage_dp_m = 4'h0; pend_m = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        e = PINS_OFF;
        n = 0; frames = 0; shadow_m = 16'h0; stage_m = 16'h0;
        sdp_m = 4'h0; stage_dp_m = 4'h0; pend_m = 1'b0;
      end else begin
        slot       = (n / TICK_DIV) % ND;
        pwm        = (n % TICK_DIV) % 16;
        frame_edge = ((n % FRAME_LEN) == FRAME_LEN - 1);
        v          = 4'((shadow_m >> (4 * slot)) & 16'h000F);
        blank      = lzs && (slot != 0) && ((shadow_m >> (4 * slot)) == 16'h0);
`ifdef SEG7_BLINK_EN
        if ((((frames / BF) % 2) == 1) && blink[slot]) blank = 1'b1;
`endif
        lit = (brightness == 4'hF) || (pwm < int'(brightness));
        if (lit && !blank) begin
          e.an  = 4'hF & ~(4'h1 << slot);
          e.seg = exp_seg(v);
          e.dp  = ~sdp_m[slot];
        end else begin
          e = PINS_OFF;
        end
        if (load && frame_edge) begin
          shadow_m = input_hex; sdp_m = dp_in; pend_m = 1'b0;
        end else if (load) begin
          stage_m = input_hex; stage_dp_m = dp_in; pend_m = 1'b1;
        end else if (frame_edge && pend_m) begin
          shadow_m = stage_m; sdp_m = stage_dp_m; pend_m = 1'b0;
        end
        if (frame_edge) frames++;
        n++;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT pins against the model on every falling edge
  initial begin : monitor
    pins_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({an, seg, dp} !== e) begin
          errors++;
          $display("FAIL pins @%0t: got an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                   $time, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic do_load(input logic [15:0] hex, input logic [3:0] dpv);
    input_hex = hex;
    dp_in     = dpv;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  // Bounded wait until the anode pins show a given pattern
  task automatic wait_an(input logic [3:0] target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (an === target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_an: got an=%b after timeout, required %b", an, target);
    end
  endtask

  // Count lit cycles (any digit, and digit 0) over a window
  task automatic count_lit(input int len, output int total, output int d0);
    total = 0;
    d0    = 0;
    for (int i = 0; i < len; i++) begin
      if (an !== 4'hF) total++;
      if (an === 4'b1110) d0++;
      @(negedge clk);
    end
  endtask

  initial begin : stimulus
    int total;
    int d0;
    rst = 1'b1; input_hex = 16'h0; dp_in = 4'h0; load = 1'b0;
    brightness = 4'hF; lzs = 1'b0; blink = 4'h0;
    cyc(3);
    rst = 1'b0;

    // Scan of 0x1234 with decimal point on digit 1
    cyc(20);
    do_load(16'h1234, 4'b0010);
    cyc(140);
    wait_an(4'b1110); check("seg_d0_4", {25'h0, seg}, 32'h19); check("dp_d0_off", {31'h0, dp}, 32'h1);
    wait_an(4'b1101); check("seg_d1_3", {25'h0, seg}, 32'h30); check("dp_d1_on", {31'h0, dp}, 32'h0);

    // Tear-free load during digit 1
    do_load(16'hABCD, 4'b0000);
    wait_an(4'b1011); check("tear_d2_2", {25'h0, seg}, 32'h24);
    wait_an(4'b0111); check("tear_d3_1", {25'h0, seg}, 32'h79);
    wait_an(4'b1110); check("new_d0_D", {25'h0, seg}, 32'h21);
    wait_an(4'b1101); check("new_d1_C", {25'h0, seg}, 32'h46);
    wait_an(4'b1011); check("new_d2_B", {25'h0, seg}, 32'h03);
    wait_an(4'b0111); check("new_d3_A", {25'h0, seg}, 32'h08);

    // Brightness
    brightness = 4'd4; cyc(2);
    count_lit(FRAME_LEN, total, d0);
    check("bright4_total", total, 32'd16); check("bright4_d0", d0, 32'd4);
    brightness = 4'd0; cyc(2);
    count_lit(FRAME_LEN, total, d0);
    check("bright0_total", total, 32'd0);
    brightness = 4'hF;

    // Leading-zero suppression
    lzs = 1'b1;
    do_load(16'h0050, 4'h0);
    cyc(140);
    count_lit(FRAME_LEN, total, d0);
    check("lzs50_total", total, 32'd32); check("lzs50_d0", d0, 32'd16);
    wait_an(4'b1101); check("lzs50_d1", {25'h0, seg}, 32'h12);
    wait_an(4'b1110); check("lzs50_d0seg", {25'h0, seg}, 32'h40);
    do_load(16'h0000, 4'h0);
    cyc(140);
    count_lit(FRAME_LEN, total, d0);
    check("lzs0_total", total, 32'd16); check("lzs0_d0", d0, 32'd16);
    lzs = 1'b0;

`ifdef SEG7_BLINK_EN
    // Blink digit 0 with BLINK_FRAMES = 2
    do_load(16'h1111, 4'h0);
    cyc(140);
    blink = 4'b0001; cyc(2);
    count_lit(4 * FRAME_LEN, total, d0);
    check("blink_d0", d0, 32'd32); check("blink_total", total, 32'd224);
    blink = 4'b0000;
`endif

    // Reset mid-frame discards a pending load
    cyc(7);
    do_load(16'h9999, 4'hF);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    check("rst_an", {28'h0, an}, 32'hF); check("rst_seg", {25'h0, seg}, 32'h7F); check("rst_dp", {31'h0, dp}, 32'h1);
    cyc(2);
    rst = 1'b0;
    cyc(140);
    count_lit(FRAME_LEN, total, d0);
    check("post_rst_total", total, 32'd64);
    wait_an(4'b1011); check("post_rst_shadow0", {25'h0, seg}, 32'h40);

    // Randomized traffic, checked by the scoreboard
    for (int it = 0; it < 60; it++) begin
      logic [15:0] h;
      h = 16'($urandom());
      h = h >> (4 * $urandom_range(0, 3));
      input_hex  = h;
      dp_in      = 4'($urandom());
      brightness = 4'($urandom_range(0, 15));
      lzs        = 1'($urandom());
      blink      = 4'($urandom());
      if ($urandom_range(0, 1) == 1) begin
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
      end
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
      cyc($urandom_range(1, 90));
    end

    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
